// File: rtl/controle_principal_multiciclo_pkg.sv
// nRISC main control: shared opcodes, states, alu_op and mux codes.
// Also holds the control-word layout used by the output decoder.
package controle_principal_multiciclo_pkg;

   localparam logic [2:0] OP_R    = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_LW   = 3'b010;
   localparam logic [2:0] OP_SW   = 3'b011;
   localparam logic [2:0] OP_BEQ  = 3'b100;
   localparam logic [2:0] OP_BNE  = 3'b101;
   localparam logic [2:0] OP_JMP  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_ALU   = 4'd7,
      S_WB_MEM   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_HALTED   = 4'd11
   } state_t;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_IMM   = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG = 2'b00;
   localparam logic [1:0] SRCB_ONE = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;
   localparam logic [1:0] SRCB_OFF = 2'b11;

   typedef struct packed {
      logic       ir_write;
      logic       pc_en;
      logic [1:0] pc_source;
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       reg_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       halted;
   } ctrl_word_t;

   // States whose exit to FETCH retires an instruction.
   function automatic logic is_retire(logic [3:0] s);
      return (s == S_WB_ALU) || (s == S_WB_MEM) ||
             (s == S_MEM_WR) || (s == S_BRANCH) ||
             (s == S_JUMP);
   endfunction

endpackage

// File: rtl/controle_principal_multiciclo_if.sv
// Controller <-> datapath bundle: IR/flag/memory inputs,
// enables, mux selects, alu_op and debug outputs.
interface controle_principal_multiciclo_if #(
   parameter int CNT_W = 16
);
   logic [2:0]       opcode;
   logic             zero;
   logic             mem_ready;
   logic             ir_write;
   logic             pc_en;
   logic [1:0]       pc_source;
   logic             mem_read;
   logic             mem_write;
   logic             i_or_d;
   logic             reg_write;
   logic             mem_to_reg;
   logic             reg_dst;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic             halted;
   logic [3:0]       state;
   logic [CNT_W-1:0] instr_count;

   modport master (
      input  opcode, zero, mem_ready,
      output ir_write, pc_en, pc_source,
      output mem_read, mem_write, i_or_d,
      output reg_write, mem_to_reg, reg_dst,
      output alu_src_a, alu_src_b, alu_op,
      output halted, state, instr_count
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  ir_write, pc_en, pc_source,
      input  mem_read, mem_write, i_or_d,
      input  reg_write, mem_to_reg, reg_dst,
      input  alu_src_a, alu_src_b, alu_op,
      input  halted, state, instr_count
   );
endinterface

// File: rtl/controle_principal_multiciclo_decod_saidas_controle.sv
// Moore decode of the control state into the datapath control word.
// Unknown state codes decode to an all-zero word.
module decod_saidas_controle
   import controle_principal_multiciclo_pkg::*;
(
   input  logic [3:0] state,
   input  logic       reg_dst_q,
   output ctrl_word_t cw
);

   // Per-state control word; unlisted fields stay 0.
   always_comb begin
      cw = '0;
      case (state)
         S_FETCH: begin
            cw.mem_read  = 1'b1;
            cw.alu_src_b = SRCB_ONE;
            cw.alu_op    = ALU_ADD;
            cw.pc_source = PCS_ALU;
         end
         S_DECODE: begin
            cw.alu_src_b = SRCB_OFF;
            cw.alu_op    = ALU_ADD;
         end
         S_EXEC_R: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_REG;
            cw.alu_op    = ALU_FUNCT;
         end
         S_EXEC_I: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_IMM;
            cw.alu_op    = ALU_IMM;
         end
         S_MEM_ADDR: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_IMM;
            cw.alu_op    = ALU_ADD;
         end
         S_MEM_RD: begin
            cw.mem_read = 1'b1;
            cw.i_or_d   = 1'b1;
         end
         S_MEM_WR: begin
            cw.mem_write = 1'b1;
            cw.i_or_d    = 1'b1;
         end
         S_WB_ALU: begin
            cw.reg_write = 1'b1;
            cw.reg_dst   = reg_dst_q;
         end
         S_WB_MEM: begin
            cw.reg_write  = 1'b1;
            cw.mem_to_reg = 1'b1;
         end
         S_BRANCH: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_REG;
            cw.alu_op    = ALU_SUB;
            cw.pc_source = PCS_ALUOUT;
         end
         S_JUMP: begin
            cw.pc_source = PCS_JUMP;
            cw.pc_en     = 1'b1;
         end
         S_HALTED: begin
            cw.halted = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/controle_principal_multiciclo.sv
// nRISC multicycle main control FSM: state register, latched
// opcode/reg_dst, Mealy PC/IR qualifiers, retired counter.
module controle_principal_multiciclo
   import controle_principal_multiciclo_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input logic clk,
   input logic reset,
   controle_principal_multiciclo_if.master bus
);

   logic [3:0]       state_q;
   logic [3:0]       state_d;
   logic [2:0]       op_q;
   logic             reg_dst_q;
   logic [CNT_W-1:0] cnt_q;
   logic             retire;
   ctrl_word_t       cw;

   decod_saidas_controle u_decod (
      .state     (state_q),
      .reg_dst_q (reg_dst_q),
      .cw        (cw)
   );

   // Next state and retire strobe.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:
            state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               OP_R:    state_d = S_EXEC_R;
               OP_ADDI: state_d = S_EXEC_I;
               OP_LW,
               OP_SW:   state_d = S_MEM_ADDR;
               OP_BEQ,
               OP_BNE:  state_d = S_BRANCH;
               OP_JMP:  state_d = S_JUMP;
               default: state_d = S_HALTED;
            endcase
         end
         S_EXEC_R,
         S_EXEC_I:
            state_d = S_WB_ALU;
         S_MEM_ADDR:
            state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:
            state_d = bus.mem_ready ? S_WB_MEM : S_MEM_RD;
         S_MEM_WR:
            state_d = bus.mem_ready ? S_FETCH : S_MEM_WR;
         S_HALTED:
            state_d = S_HALTED;
         default:
            state_d = S_FETCH;
      endcase
      retire = (state_d == S_FETCH) && is_retire(state_q);
   end

   // State, decode-time latches and retired counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         op_q      <= OP_R;
         reg_dst_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            op_q      <= bus.opcode;
            reg_dst_q <= (bus.opcode == OP_R);
         end
         if (retire)
            cnt_q <= cnt_q + 1'b1;
      end
   end

   // PC/IR loads qualified by the handshake and branch outcome.
   always_comb begin
      bus.ir_write = cw.ir_write;
      bus.pc_en    = cw.pc_en;
      if (state_q == S_FETCH) begin
         bus.ir_write = bus.mem_ready;
         bus.pc_en    = bus.mem_ready;
      end else if (state_q == S_BRANCH) begin
         bus.pc_en = (op_q == OP_BNE) ? ~bus.zero : bus.zero;
      end
   end

   assign bus.pc_source   = cw.pc_source;
   assign bus.mem_read    = cw.mem_read;
   assign bus.mem_write   = cw.mem_write;
   assign bus.i_or_d      = cw.i_or_d;
   assign bus.reg_write   = cw.reg_write;
   assign bus.mem_to_reg  = cw.mem_to_reg;
   assign bus.reg_dst     = cw.reg_dst;
   assign bus.alu_src_a   = cw.alu_src_a;
   assign bus.alu_src_b   = cw.alu_src_b;
   assign bus.alu_op      = cw.alu_op;
   assign bus.halted      = cw.halted;
   assign bus.state       = state_q;
   assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_controle_principal_multiciclo.sv
// Scoreboard bench for the nRISC multicycle main control FSM.
// Driver queues expected per-cycle outputs; monitor compares.
module tb_controle_principal_multiciclo;

   localparam int CW = 4;

   logic clk = 1'b0;
   logic reset;

   controle_principal_multiciclo_if #(.CNT_W(CW)) bus ();

   controle_principal_multiciclo #(.CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [3:0] st;
      logic [15:0] w;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_cyc  = 0;
   logic [CW-1:0] ecnt;

   // Field order: irw pce pcs mr mw iod rw m2r rdst asa asb aop h
   function automatic logic [15:0] mk(
      logic irw, logic pce, logic [1:0] pcs,
      logic mr, logic mw, logic iod, logic rw,
      logic m2r, logic rdst, logic asa,
      logic [1:0] asb, logic [1:0] aop, logic h);
      return {irw, pce, pcs, mr, mw, iod, rw,
              m2r, rdst, asa, asb, aop, h};
   endfunction

   // Hand-written expected control word per state.
   function automatic logic [15:0] ref_word(
      logic [3:0] st, logic irw, logic pce, logic rdst);
      case (st)
         4'd0:  return mk(irw,pce,2'b00,1,0,0,0,0,0,0,2'b01,2'b00,0);
         4'd1:  return mk(0,0,2'b00,0,0,0,0,0,0,0,2'b11,2'b00,0);
         4'd2:  return mk(0,0,2'b00,0,0,0,0,0,0,1,2'b00,2'b10,0);
         4'd3:  return mk(0,0,2'b00,0,0,0,0,0,0,1,2'b10,2'b11,0);
         4'd4:  return mk(0,0,2'b00,0,0,0,0,0,0,1,2'b10,2'b00,0);
         4'd5:  return mk(0,0,2'b00,1,0,1,0,0,0,0,2'b00,2'b00,0);
         4'd6:  return mk(0,0,2'b00,0,1,1,0,0,0,0,2'b00,2'b00,0);
         4'd7:  return mk(0,0,2'b00,0,0,0,1,0,rdst,0,2'b00,2'b00,0);
         4'd8:  return mk(0,0,2'b00,0,0,0,1,1,0,0,2'b00,2'b00,0);
         4'd9:  return mk(0,pce,2'b01,0,0,0,0,0,0,1,2'b00,2'b01,0);
         4'd10: return mk(0,1,2'b10,0,0,0,0,0,0,0,2'b00,2'b00,0);
         4'd11: return mk(0,0,2'b00,0,0,0,0,0,0,0,2'b00,2'b00,1);
         default: return 16'h0;
      endcase
   endfunction

   // One cycle: apply inputs after the edge, queue expectation.
   task automatic cyc(input logic r, input logic [2:0] op,
                      input logic z, input logic rdy,
                      input logic [3:0] st, input logic irw,
                      input logic pce, input logic rdst);
      exp_t e;
      @(posedge clk);
      #1;
      reset         = r;
      bus.opcode    = op;
      bus.zero      = z;
      bus.mem_ready = rdy;
      e.id  = n_cyc;
      e.st  = st;
      e.w   = ref_word(st, irw, pce, rdst);
      e.cnt = ecnt;
      q.push_back(e);
      n_cyc++;
   endtask

   task automatic fetch(input logic rdy);
      cyc(0, 3'b111, 0, rdy, 4'd0, rdy, rdy, 0);
   endtask

   task automatic decode(input logic [2:0] op);
      cyc(0, op, 0, 0, 4'd1, 0, 0, 0);
   endtask

   task automatic r_type();
      fetch(1);
      decode(3'b000);
      cyc(0, 3'b111, 0, 0, 4'd2, 0, 0, 0);
      cyc(0, 3'b111, 0, 0, 4'd7, 0, 0, 1);
      ecnt = ecnt + 1'b1;
   endtask

   task automatic branch(input logic [2:0] op, input logic z,
                         input logic pce);
      fetch(1);
      decode(op);
      cyc(0, 3'b111, z, 0, 4'd9, 0, pce, 0);
      ecnt = ecnt + 1'b1;
   endtask

   // Monitor: compare the visible outputs mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [15:0] got;
         e = q.pop_front();
         got = {bus.ir_write, bus.pc_en, bus.pc_source,
                bus.mem_read, bus.mem_write, bus.i_or_d,
                bus.reg_write, bus.mem_to_reg, bus.reg_dst,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.halted};
         n_chk++;
         if (bus.state === e.st && got === e.w &&
             bus.instr_count === e.cnt)
            n_pass++;
         else
            $display("FAIL cyc%0d: got st=%0d w=%h cnt=%0d want st=%0d w=%h cnt=%0d",
                     e.id, bus.state, got, bus.instr_count,
                     e.st, e.w, e.cnt);
      end
   end

   initial begin
      reset         = 1'b1;
      bus.opcode    = 3'b000;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      ecnt          = '0;
      @(posedge clk);

      // R-type: 0,1,2,7 then FETCH with count 1
      r_type();

      // ADDI: reg_dst 0 in WB_ALU
      fetch(1);
      decode(3'b001);
      cyc(0, 3'b111, 0, 0, 4'd3, 0, 0, 0);
      cyc(0, 3'b111, 0, 0, 4'd7, 0, 0, 0);
      ecnt = ecnt + 1'b1;

      // LW, two stall cycles in MEM_RD; opcode changes after DECODE
      fetch(1);
      decode(3'b010);
      cyc(0, 3'b011, 0, 0, 4'd4, 0, 0, 0);
      cyc(0, 3'b111, 0, 0, 4'd5, 0, 0, 0);
      cyc(0, 3'b111, 0, 0, 4'd5, 0, 0, 0);
      cyc(0, 3'b111, 0, 1, 4'd5, 0, 0, 0);
      cyc(0, 3'b111, 0, 0, 4'd8, 0, 0, 0);
      ecnt = ecnt + 1'b1;

      // SW, one stall cycle in MEM_WR
      fetch(1);
      decode(3'b011);
      cyc(0, 3'b010, 0, 0, 4'd4, 0, 0, 0);
      cyc(0, 3'b111, 0, 0, 4'd6, 0, 0, 0);
      cyc(0, 3'b111, 0, 1, 4'd6, 0, 0, 0);
      ecnt = ecnt + 1'b1;

      // Branches: BEQ/BNE with zero 1 and 0
      branch(3'b100, 1, 1);
      branch(3'b101, 1, 0);
      branch(3'b100, 0, 0);
      branch(3'b101, 0, 1);

      // JMP
      fetch(1);
      decode(3'b110);
      cyc(0, 3'b111, 0, 0, 4'd10, 0, 1, 0);
      ecnt = ecnt + 1'b1;

      // FETCH stalled three cycles, then an R-type
      fetch(0);
      fetch(0);
      fetch(0);
      r_type();

      // HALT: count frozen, reset releases
      fetch(1);
      decode(3'b111);
      cyc(0, 3'b000, 0, 1, 4'd11, 0, 0, 0);
      cyc(0, 3'b000, 0, 1, 4'd11, 0, 0, 0);
      cyc(1, 3'b000, 0, 1, 4'd11, 0, 0, 0);
      ecnt = '0;
      fetch(0);

      // Reset during an SW stall
      fetch(1);
      decode(3'b011);
      cyc(0, 3'b111, 0, 0, 4'd4, 0, 0, 0);
      cyc(0, 3'b111, 0, 0, 4'd6, 0, 0, 0);
      cyc(1, 3'b111, 0, 0, 4'd6, 0, 0, 0);
      ecnt = '0;
      fetch(0);

      // Counter wrap: 16 R-types on a 4-bit counter
      for (int i = 0; i < 16; i++)
         r_type();
      fetch(0);

      @(posedge clk);
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_chk++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
